// File: rtl/ac_frame_encoder.sv
// rtl/ac_frame_encoder.sv - key debounce, AC settings and IR head/tail frame builder
//
// Ports:
//   clk, rst            system clock; synchronous active-low reset
//   key_*               raw front-panel buttons, active high, asynchronous
//   frame_ready         transmitter can accept a frame this cycle
//   frame_valid         data35_out/data32_out hold a frame awaiting acceptance
//   data35_out          35-bit head frame (mode, power, fan, swing, temp, constant)
//   data32_out          33-bit tail frame (constant, checksum)
//   power_led           current power state
//   temp_disp           current set temperature in degrees C (16..30)
module ac_frame_encoder #(
    parameter int          DEBOUNCE_CYCLES = 2500000,
    parameter logic [23:0] LOW35           = 24'h100252,
    parameter logic [28:0] HIGH32          = 29'h00802000,
    parameter logic [3:0]  CHK_OFFSET      = 4'd10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_power,
    input  logic        key_mode,
    input  logic        key_temp_up,
    input  logic        key_temp_down,
    input  logic        key_fan,
    input  logic        frame_ready,
    output logic        frame_valid,
    output logic [34:0] data35_out,
    output logic [32:0] data32_out,
    output logic        power_led,
    output logic [4:0]  temp_disp
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUILD = 2'd1,
        S_OFFER = 2'd2
    } state_t;

    // bit 0 is the highest priority key
    logic [4:0] w_keys;
    assign w_keys = {key_fan, key_temp_down, key_temp_up, key_mode, key_power};

    logic [4:0]    r_sync1;
    logic [4:0]    r_sync2;
    logic [4:0]    r_db;
    logic [4:0]    r_db_q;
    logic [CW-1:0] r_cnt [5];
    logic [4:0]    w_press;

    logic          r_power;
    logic [2:0]    r_mode;
    logic [3:0]    r_temp_off;
    logic [1:0]    r_fan;
    logic [4:0]    r_temp_disp;
    logic          r_change_req;

    state_t        r_state;
    logic          r_pending;
    logic          r_valid;
    logic [34:0]   r_data35;
    logic [32:0]   r_data32;

    logic [3:0]    w_chk;
    logic [34:0]   w_data35;
    logic [32:0]   w_data32;

    // Synchronizers and per-key debounce counters
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_db    <= '0;
            r_db_q  <= '0;
            for (int i = 0; i < 5; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= w_keys;
            r_sync2 <= r_sync1;
            r_db_q  <= r_db;
            for (int i = 0; i < 5; i++) begin
                if (r_sync2[i] != r_db[i]) begin
                    if (r_cnt[i] == CNT_LAST) begin
                        r_db[i]  <= r_sync2[i];
                        r_cnt[i] <= '0;
                    end else begin
                        r_cnt[i] <= r_cnt[i] + 1'b1;
                    end
                end else begin
                    r_cnt[i] <= '0;
                end
            end
        end
    end

    // One-cycle pulse on each 0->1 flip of a debounced level
    assign w_press = r_db & ~r_db_q;

    // Settings: only the highest-priority press in a cycle is considered;
    // the lower ones are dropped even when the winner changes nothing.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_power      <= 1'b0;
            r_mode       <= 3'd1;
            r_temp_off   <= 4'd10;
            r_fan        <= 2'd0;
            r_temp_disp  <= 5'd26;
            r_change_req <= 1'b0;
        end else begin
            r_change_req <= 1'b0;
            if (w_press[0]) begin
                r_power      <= ~r_power;
                r_change_req <= 1'b1;
            end else if (r_power) begin
                if (w_press[1]) begin
                    r_mode       <= (r_mode == 3'd4) ? 3'd0 : r_mode + 3'd1;
                    r_change_req <= 1'b1;
                end else if (w_press[2]) begin
                    if (r_temp_off != 4'd14) begin
                        r_temp_off   <= r_temp_off + 4'd1;
                        r_temp_disp  <= 5'd17 + {1'b0, r_temp_off};
                        r_change_req <= 1'b1;
                    end
                end else if (w_press[3]) begin
                    if (r_temp_off != 4'd0) begin
                        r_temp_off   <= r_temp_off - 4'd1;
                        r_temp_disp  <= 5'd15 + {1'b0, r_temp_off};
                        r_change_req <= 1'b1;
                    end
                end else if (w_press[4]) begin
                    r_fan        <= r_fan + 2'd1;
                    r_change_req <= 1'b1;
                end
            end
        end
    end

    // Checksum is a modulo-16 sum, so plain 4-bit addition gives the truncated result
    assign w_chk = r_temp_off + {1'b0, r_mode} + {2'b00, r_fan}
                 + {r_power, 3'b000} + CHK_OFFSET;

    assign w_data35 = {r_mode, r_power, r_fan, 1'b0, r_temp_off, LOW35};
    assign w_data32 = {HIGH32, w_chk};

    // Frame handshake FSM. Changes arriving while a frame is offered are
    // coalesced into one pending rebuild that samples the latest settings.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_pending <= 1'b0;
            r_valid   <= 1'b0;
            r_data35  <= '0;
            r_data32  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_change_req) begin
                        r_state <= S_BUILD;
                    end
                end
                S_BUILD: begin
                    r_data35  <= w_data35;
                    r_data32  <= w_data32;
                    r_pending <= 1'b0;
                    r_valid   <= 1'b1;
                    r_state   <= S_OFFER;
                end
                S_OFFER: begin
                    if (r_change_req) begin
                        r_pending <= 1'b1;
                    end
                    if (frame_ready) begin
                        r_valid <= 1'b0;
                        r_state <= (r_pending || r_change_req) ? S_BUILD : S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign frame_valid = r_valid;
    assign data35_out  = r_data35;
    assign data32_out  = r_data32;
    assign power_led   = r_power;
    assign temp_disp   = r_temp_disp;

endmodule

// File: doc/ac_frame_encoder.md
Name: ac_frame_encoder

Overview:
- Upstream stage of the IR transmitter. Debounces the front-panel keys and holds the air-conditioner settings: power, mode, temperature and fan.
- On every accepted setting change, assembles the 35-bit head frame and 33-bit tail frame, including a 4-bit checksum.
- Hands the pair to the transmitter over a valid/ready handshake. Transmitter sends MSB first: bit 34, then bit 32.

Parameters:
- DEBOUNCE_CYCLES, 2500000, consecutive stable cycles required to accept a raw key level (20 ms at 125 MHz).
- LOW35, 24'h100252, constant field data35[23:0].
- HIGH32, 29'h00802000, constant field data32[32:4].
- CHK_OFFSET, 4'd10, constant added into the checksum.

Ports:
- clk  input  1  system clock, 125 MHz.
- rst  input  1  reset, synchronous, active-low.
- key_power  input  1  raw button, active high, asynchronous to clk.
- key_mode  input  1  raw button, active high.
- key_temp_up  input  1  raw button, active high.
- key_temp_down  input  1  raw button, active high.
- key_fan  input  1  raw button, active high.
- frame_ready  input  1  transmitter idle and able to accept a frame.
- frame_valid  output  1  data35_out/data32_out hold a frame awaiting acceptance.
- data35_out  output  35  head frame.
- data32_out  output  33  tail frame.
- power_led  output  1  current power state.
- temp_disp  output  5  current set temperature in °C, range 16..30.

Behaviour:
- Reset: sampled on posedge clk while rst=0; clears everything, including a reset mid-debounce or mid-offer.
  - power=0, mode=1 (cool), temp_off=10 (26 °C), fan=0, pending=0, state=IDLE.
  - frame_valid=0, data35_out=0, data32_out=0, power_led=0, temp_disp=26.
  - Debounced key levels reset to 0; debounce counters reset to 0.
- Input sync: each key passes through a 2-flop synchronizer.
- Debounce: per key, a counter runs while the synchronized level differs from the debounced level and clears when they match. When the count reaches DEBOUNCE_CYCLES-1, the debounced level flips. A 0->1 flip of the debounced level produces a 1-cycle press event.
- Simultaneous presses: priority is power > mode > temp_up > temp_down > fan. Only the highest-priority event in a cycle is applied; the others are discarded.
- Setting updates, applied in the cycle after the event:
  - power: toggles.
  - mode: 0 auto, 1 cool, 2 dry, 3 fan, 4 heat; increments with wrap 4->0.
  - temp_up: temp_off+1, saturating at 14.
  - temp_down: temp_off-1, saturating at 0.
  - fan: 0..3, increments with wrap 3->0.
  - While power=0, every key except power is ignored.
  - Any applied change sets change_req. Presses at the temperature limits or ignored presses set nothing.
- Frame layout, built from registered settings:
  - data35[34:32]=mode, [31]=power, [30:29]=fan, [28]=0 (swing), [27:24]=temp_off, [23:0]=LOW35.
  - data32[32:4]=HIGH32, [3:0]=chk.
  - chk = (temp_off + mode + fan + 8*power + CHK_OFFSET) mod 16, computed in 6-bit width and truncated to 4 bits.
- FSM:
  - IDLE: on change_req -> BUILD.
  - BUILD (1 cycle): load data35_out/data32_out from current settings, clear pending -> OFFER.
  - OFFER: frame_valid=1, outputs held stable.
    - If frame_valid && frame_ready: transfer; frame_valid=0 next cycle; go to BUILD if pending, else IDLE.
    - A change during OFFER sets pending and does not alter the outputs.
    - A change in the same cycle as the transfer also sets pending.
- Latency: press event at cycle N -> setting updated at N+1 -> BUILD at N+2 -> frame_valid=1 at N+3.
- Coalescing: several changes while pending produce one frame carrying the latest settings.
- Display: temp_disp = 16 + temp_off; power_led = power; both registered and updated with the setting.

Test Plan:
- Run with DEBOUNCE_CYCLES=4. Release reset, frame_ready=1 -> frame_valid stays 0, temp_disp=26, power_led=0.
- Press key_power for 10 cycles -> exactly one frame, data35_out[34:24]=11'b001_1_00_0_1010, chk=(10+1+0+8+10) mod 16=4'd13, power_led=1.
- 2-cycle glitch on key_temp_up -> no change, no frame. Then 15 valid temp_up presses from 26 °C -> temp_disp saturates at 30; the 5th and later presses produce no frames.
- Hold frame_ready=0, then press mode and fan once each -> the first frame is held stable. Raise frame_ready -> transfer, then exactly one further frame with mode=2, fan=1.
- Press key_power and key_fan in the same cycle while on -> power=0, fan unchanged. A subsequent fan press produces no frame.
- Assert rst=0 during OFFER -> next cycle frame_valid=0 and all settings at reset values; no frame after release.
